seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 6-digit common-anode seven-segment display.
- Holds a committed ("active") frame of six hex digits with per-digit enable and decimal point, and drives one digit at a time through the active-low sel/seg_led pins.
- A new frame is loaded through a valid/ready write port into a shadow buffer and committed atomically at the end of a scan frame, so the display never tears.
- Sits between system logic that produces display values and the board's segment/select pins.

---
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Frame write port of the seven-segment scan controller.
// The producer of display values drives the master side and the scan
// controller sits on the slave side. A frame moves on a cycle where
// wr_valid and wr_ready are both high.
interface seg_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [23:0] wr_data;
    logic [5:0]  wr_en;
    logic [5:0]  wr_dp;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_en,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_en,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 6-digit common-anode display.
// A slot counter steps through the digits one at a time. Each slot opens
// with a short all-dark blanking window, which suppresses ghosting, and
// then drives one digit. New frames land in a shadow buffer. They are
// copied to the active frame only at the end of a full scan, so a frame
// is never shown half old and half new.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_ctrl_if.slave     wr,
    input  logic               lz_blank,
    output logic               frame_done,
    output logic [5:0]         sel,
    output logic [7:0]         seg_led
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    localparam phase_t RESET_PHASE = (BLANK_CYC > 0) ? PH_BLANK : PH_DRIVE;

    // Segment pattern for one hex digit, bits {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] decodeHex(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    phase_t        phase_q, phase_d;

    logic [23:0]   actData_q, actData_d;
    logic [5:0]    actEn_q, actEn_d;
    logic [5:0]    actDp_q, actDp_d;

    logic          shadowFull_q, shadowFull_d;
    logic [23:0]   shadowData_q, shadowData_d;
    logic [5:0]    shadowEn_q, shadowEn_d;
    logic [5:0]    shadowDp_q, shadowDp_d;

    logic          frameDone_q;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    logic          boundary;
    logic          accept;
    logic [5:0]    leadZero;
    logic [5:0]    lzMask;
    logic [3:0]    curDigit;
    logic          visible;

    assign boundary   = (idx_q == 3'd5) && (cnt_q == CNT_MAX);
    assign accept     = wr.wr_valid && !shadowFull_q;
    assign wr.wr_ready = !shadowFull_q;
    assign frame_done = frameDone_q;
    assign sel        = sel_q;
    assign seg_led    = seg_q;

    // Slot timing. The counter wraps once per slot and advances the digit
    // index. The phase is decided from the upcoming count, so the phase
    // register always describes the slot position held in cnt_q.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        if (cnt_d < BLANK_END) begin
            phase_d = PH_BLANK;
        end else begin
            phase_d = PH_DRIVE;
        end
    end

    // Shadow buffer and commit. While the shadow is full it refuses new
    // writes. A full shadow is emptied into the active frame only on the
    // boundary cycle. A write accepted on that same cycle found the shadow
    // empty, so it waits for the next boundary.
    always_comb begin
        actData_d    = actData_q;
        actEn_d      = actEn_q;
        actDp_d      = actDp_q;
        shadowFull_d = shadowFull_q;
        shadowData_d = shadowData_q;
        shadowEn_d   = shadowEn_q;
        shadowDp_d   = shadowDp_q;
        if (boundary && shadowFull_q) begin
            actData_d    = shadowData_q;
            actEn_d      = shadowEn_q;
            actDp_d      = shadowDp_q;
            shadowFull_d = 1'b0;
        end else if (accept) begin
            shadowData_d = wr.wr_data;
            shadowEn_d   = wr.wr_en;
            shadowDp_d   = wr.wr_dp;
            shadowFull_d = 1'b1;
        end
    end

    // Leading-zero chain. It starts at the top digit and stays alive only
    // through enabled zero digits. Digit 0 always stays outside the chain,
    // so a value of zero still shows a single "0".
    always_comb begin
        leadZero    = 6'b0;
        leadZero[5] = (actData_q[23:20] == 4'h0);
        for (int k = 4; k >= 1; k--) begin
            leadZero[k] = leadZero[k+1] && actEn_q[k+1]
                          && (actData_q[4*k +: 4] == 4'h0);
        end
        lzMask = lz_blank ? leadZero : 6'b0;
    end

    // Next values for the registered pins, from the current slot state.
    always_comb begin
        curDigit = actData_q[idx_q*4 +: 4];
        visible  = actEn_q[idx_q] && !lzMask[idx_q];
        sel_d    = 6'h3F;
        seg_d    = 8'hFF;
        if (phase_q == PH_DRIVE && visible) begin
            sel_d = ~(6'b1 << idx_q);
            seg_d = {~actDp_q[idx_q], decodeHex(curDigit)};
        end
    end

    // State and output registers. Reset blanks the pins at once, clears
    // the active frame and drops any frame still waiting in the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            phase_q      <= RESET_PHASE;
            actData_q    <= '0;
            actEn_q      <= '0;
            actDp_q      <= '0;
            shadowFull_q <= 1'b0;
            shadowData_q <= '0;
            shadowEn_q   <= '0;
            shadowDp_q   <= '0;
            frameDone_q  <= 1'b0;
            sel_q        <= 6'h3F;
            seg_q        <= 8'hFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            actData_q    <= actData_d;
            actEn_q      <= actEn_d;
            actDp_q      <= actDp_d;
            shadowFull_q <= shadowFull_d;
            shadowData_q <= shadowData_d;
            shadowEn_q   <= shadowEn_d;
            shadowDp_q   <= shadowDp_d;
            frameDone_q  <= boundary;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl. A reference model steps once per
// cycle from the scan position and the frame contents. It queues the pin
// values expected one cycle later. A monitor on the falling edge pops
// those entries and compares them against the DUT.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 6 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       lz_blank;
    logic       frame_done;
    logic [5:0] sel;
    logic [7:0] seg_led;

    seg_scan_ctrl_if wrIf ();

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wrIf.slave),
        .lz_blank   (lz_blank),
        .frame_done (frame_done),
        .sel        (sel),
        .seg_led    (seg_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned tag;
        logic [5:0]  sel;
        logic [7:0]  seg;
        logic        fd;
        logic        rdy;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [7:0] segTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state: scan position within the frame, the active
    // frame and the shadow frame.
    int          mPos;
    logic [23:0] mData, sData;
    logic [5:0]  mEn, mDp, sEn, sDp;
    bit          mFull;
    bit          mAccepted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic modelStep();
        exp_t e;
        int   slot, off;
        bit   blk [6];
        bit   vis;
        logic [3:0] dig;
        e.tag     = cyc + 1;
        mAccepted = 1'b0;
        if (rst) begin
            e.sel = 6'h3F; e.seg = 8'hFF; e.fd = 1'b0; e.rdy = 1'b1;
            mPos = 0; mData = '0; mEn = '0; mDp = '0;
            sData = '0; sEn = '0; sDp = '0; mFull = 1'b0;
        end else begin
            slot = mPos / CLK_DIV;
            off  = mPos % CLK_DIV;
            foreach (blk[k]) blk[k] = 1'b0;
            if (lz_blank) begin
                for (int k = 5; k >= 1; k--) begin
                    if (((mData >> (4*k)) & 24'hF) != 0 || !mEn[k]) break;
                    blk[k] = 1'b1;
                end
            end
            vis = mEn[slot] && !blk[slot];
            dig = 4'((mData >> (4*slot)) & 24'hF);
            e.sel = 6'h3F;
            e.seg = 8'hFF;
            if (off >= BLANK_CYC && vis) begin
                e.sel = 6'h3F ^ 6'(1 << slot);
                e.seg = mDp[slot] ? (segTab[dig] & 8'h7F) : segTab[dig];
            end
            e.fd = (mPos == FRAME - 1);
            if (e.fd && mFull) begin
                mData = sData; mEn = sEn; mDp = sDp; mFull = 1'b0;
            end else if (wrIf.wr_valid && !mFull) begin
                sData = wrIf.wr_data; sEn = wrIf.wr_en; sDp = wrIf.wr_dp;
                mFull = 1'b1; mAccepted = 1'b1;
            end
            e.rdy = !mFull;
            mPos  = (mPos + 1) % FRAME;
        end
        sbq.push_back(e);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offers a frame and holds wr_valid until the model has taken it.
    task automatic applyStimulus(input logic [23:0] data, input logic [5:0] en,
                                 input logic [5:0] dp);
        bit got = 1'b0;
        wrIf.wr_valid = 1'b1;
        wrIf.wr_data  = data;
        wrIf.wr_en    = en;
        wrIf.wr_dp    = dp;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            tick();
            got = mAccepted;
        end
        wrIf.wr_valid = 1'b0;
        wrIf.wr_data  = 24'($urandom);
        wrIf.wr_en    = 6'($urandom);
        wrIf.wr_dp    = 6'($urandom);
        total++;
        if (!got) begin
            bad++;
            $display("[TB] FAIL write_accept data=%h not accepted within %0d cycles",
                     data, 4 * FRAME);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every expectation whose target cycle has come.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            e = sbq.pop_front();
            if (e.tag != cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL stale_entry tag=%0d cyc=%0d", e.tag, cyc);
            end else begin
                checkOutput("sel",        {2'b00, sel},             {2'b00, e.sel});
                checkOutput("seg_led",    seg_led,                  e.seg);
                checkOutput("frame_done", {7'b0, frame_done},       {7'b0, e.fd});
                checkOutput("wr_ready",   {7'b0, wrIf.wr_ready},    {7'b0, e.rdy});
            end
        end
    end

    initial begin
        rst           = 1'b1;
        lz_blank      = 1'b0;
        wrIf.wr_valid = 1'b0;
        wrIf.wr_data  = '0;
        wrIf.wr_en    = '0;
        wrIf.wr_dp    = '0;
        mPos = 0; mData = '0; mEn = '0; mDp = '0;
        sData = '0; sEn = '0; sDp = '0; mFull = 1'b0; mAccepted = 1'b0;

        runCycles(3);
        rst = 1'b0;
        runCycles(2 * FRAME);

        $display("[TB] frame 123456");
        applyStimulus(24'h123456, 6'h3F, 6'h00);
        runCycles(2 * FRAME);

        $display("[TB] back-to-back writes");
        applyStimulus(24'hABCDEF, 6'h3F, 6'h2A);
        applyStimulus(24'h987654, 6'h3F, 6'h15);
        runCycles(2 * FRAME);

        $display("[TB] leading-zero blanking");
        lz_blank = 1'b1;
        applyStimulus(24'h000405, 6'h3F, 6'h00);
        runCycles(2 * FRAME);
        lz_blank = 1'b0;
        runCycles(FRAME);

        $display("[TB] decimal point on digit 0");
        applyStimulus(24'h000008, 6'h01, 6'h01);
        runCycles(2 * FRAME);

        $display("[TB] reset with pending shadow");
        for (int i = 0; i < FRAME && mPos != 3; i++) tick();
        applyStimulus(24'h777777, 6'h3F, 6'h3F);
        runCycles(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runCycles(2 * FRAME);

        $display("[TB] random frames");
        for (int n = 0; n < 25; n++) begin
            lz_blank = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(24'($urandom) & 24'h00F0FF, 6'($urandom), 6'($urandom));
            else
                applyStimulus(24'($urandom), 6'($urandom), 6'($urandom));
            runCycles($urandom_range(0, 70));
            if (n == 12) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        runCycles(2 * FRAME);

        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
